fifo_read_ctrl: RTL and testbench
=================================

// Module: fifo_read_ctrl
// PURPOSE
//  Read-domain controller of the async FIFO; pairs with the write-side logic driven through fifo_write_inf.
//  Owns read pointer, memory read address and registered empty flag in rclk domain.
//  Brings write Gray pointer into rclk via a 2-flop synchronizer and exports read Gray pointer to write side.
//  Sits between the dual-port FIFO memory read port and the read-side consumer.
// PARAMETERS
//  ASIZE      4  address bits; FIFO depth = 2**ASIZE; pointers are ASIZE+1 bits
//  AE_THRESH  2  almost-empty threshold in entries (used only with FIFO_RD_ALMOST_EMPTY_EN)
// PORTS
//  rclk           in   1        read clock; all state on posedge
//  rrst           in   1        synchronous, active-high reset
//  rinc           in   1        read request; pops one entry when rempty==0
//  wptr_gray      in   ASIZE+1  write Gray pointer from wclk domain (async; synchronized inside)
//  rptr_gray      out  ASIZE+1  registered read Gray pointer, to write-side full logic
//  raddr          out  ASIZE    memory read address = rbin[ASIZE-1:0]
//  rempty         out  1        registered empty flag
//  rlevel         out  ASIZE+1  occupancy seen by read side (FIFO_RD_ALMOST_EMPTY_EN only)
//  ralmost_empty  out  1        rlevel <= AE_THRESH (FIFO_RD_ALMOST_EMPTY_EN only)
// BEHAVIOUR
//  - One clock (rclk); reset synchronous, active-high (rrst).
//  - Reset (rrst=1 at posedge): rbin=0, rptr_gray=0, raddr=0, rempty=1, sync flops=0; rlevel=0, ralmost_empty=1.
//  - Reset has priority over rinc; mid-operation reset discards unread data and returns rclk side to empty.
//  - Synchronizer: rq1<=wptr_gray, rq2<=rq1; no logic between the two stages.
//  - Pop: rd_en = rinc & ~rempty; rbin_next = rbin + rd_en (ASIZE+1 bits, wraps 2**(ASIZE+1)-1 -> 0).
//  - rgray_next = rbin_next ^ (rbin_next >> 1); rptr_gray <= rgray_next; raddr comes from rbin (registered).
//  - rempty <= (rgray_next == rq2); exact Gray compare, all ASIZE+1 bits.
//  - rinc while rempty=1: ignored; pointers unchanged, no underflow.
//  - Read of last entry: rempty rises the same edge rbin advances; next rinc ignored.
//  - Data timing: raddr valid when rempty=0; memory read is outside this block; entry consumed on the rd_en edge.
//  - Write-to-empty latency: wptr_gray change -> rempty falls on 3rd rclk posedge (2 sync + 1 flag register).
//  - Empty flag is pessimistic: it may lag true state (deasserts late), never asserts falsely low.
//  - rptr_gray changes by at most one bit per rclk (Gray property); required for safe CDC.
// CONFIGURATION
//  FIFO_RD_ALMOST_EMPTY_EN defined:
//   - rq2 converted to binary (wbin_s); rlevel <= wbin_s - rbin_next (mod 2**(ASIZE+1)); range 0..2**ASIZE.
//   - ralmost_empty <= (wbin_s - rbin_next) <= AE_THRESH; both registered, same edge as rempty.
//  FIFO_RD_ALMOST_EMPTY_EN undefined:
//   - rlevel/ralmost_empty ports absent, no Gray-to-binary logic; all other behaviour identical.
// STRUCTURE
//  - fifo_pkg: functions bin2gray/gray2bin (parameterized by width), localparam PTR_W = ASIZE+1.
//  - Sub-module fifo_sync2: generic 2-flop synchronizer (WIDTH param, clk, rst active-high sync).
//  - fifo_read_ctrl instantiates one fifo_sync2 (WIDTH=ASIZE+1); pointer/flag logic local.
// TESTING (ASIZE=4, AE_THRESH=2)
//  1 Reset: rrst=1 two cycles, wptr_gray=5'b00000 -> rempty=1, raddr=0, rptr_gray=0; rinc=1 no effect.
//  2 Write-to-empty latency: wptr_gray 0->1 at cycle N -> rempty=0 at posedge N+3; rinc=1 -> raddr 0->1, rempty=1 next edge.
//  3 Drain full: wptr_gray=bin2gray(16), rinc=1 held -> 16 pops, raddr 0..15, rempty=1 after 16th, rptr_gray=5'b11000.
//  4 Wrap: loop 40 write/read pairs -> rbin wraps 31->0, rptr_gray 5'b10000->5'b00000, one bit flips per edge, no false empty.
//  5 Underflow/reset mid-op: with 3 entries pop 1, assert rrst -> rempty=1, raddr=0; rinc while empty leaves rptr_gray fixed.
//  6 Almost-empty (macro on): occupancy 5 -> rlevel=5, ralmost_empty=0; pop 3 -> rlevel=2, ralmost_empty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared pointer width and Gray/binary helpers for the async FIFO
package fifo_pkg;

    localparam int ASIZE_DEF = 4;
    localparam int PTR_W     = ASIZE_DEF + 1;

    // Helpers work on a fixed wide vector; callers zero-extend narrower pointers,
    // which leaves the conversion of the low bits unchanged.
    localparam int MAX_W = 16;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync2.sv
// rtl/fifo_sync2.sv - generic two-flop synchronizer with synchronous active-high reset
module fifo_sync2 #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1;

    always_ff @(posedge clk) begin
        if (rst) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - read-domain pointer/empty controller of the async FIFO
// FIFO_RD_ALMOST_EMPTY_EN adds the registered rlevel and ralmost_empty outputs.
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int ASIZE     = PTR_W - 1,
    parameter int AE_THRESH = 2
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rinc,
    input  logic [ASIZE:0]   wptr_gray,
    output logic [ASIZE:0]   rptr_gray,
    output logic [ASIZE-1:0] raddr,
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    output logic [ASIZE:0]   rlevel,
    output logic             ralmost_empty,
`endif
    output logic             rempty
);

    localparam int PW  = ASIZE + 1;
    localparam int PAD = MAX_W - PW;

    logic [PW-1:0]  rbin;
    logic [PW-1:0]  rq2;
    logic [PW-1:0]  rbin_next;
    logic [PW-1:0]  rgray_next;
    logic [PAD-1:0] gray_pad_unused;
    logic           rd_en;

    fifo_sync2 #(.WIDTH(PW)) u_wptr_sync (
        .clk (rclk),
        .rst (rrst),
        .d   (wptr_gray),
        .q   (rq2)
    );

    assign rd_en     = rinc & ~rempty;
    assign rbin_next = rbin + PW'(rd_en);
    assign {gray_pad_unused, rgray_next} = bin2gray({{PAD{1'b0}}, rbin_next});
    assign raddr     = rbin[ASIZE-1:0];

    // Comparing against the synchronized (stale) write pointer keeps empty pessimistic.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin      <= '0;
            rptr_gray <= '0;
            rempty    <= 1'b1;
        end else begin
            rbin      <= rbin_next;
            rptr_gray <= rgray_next;
            rempty    <= (rgray_next == rq2);
        end
    end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
    logic [PAD-1:0] wbin_pad_unused;
    logic [PW-1:0]  wbin_s;
    logic [PW-1:0]  level_next;

    assign {wbin_pad_unused, wbin_s} = gray2bin({{PAD{1'b0}}, rq2});
    assign level_next = wbin_s - rbin_next;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rlevel        <= '0;
            ralmost_empty <= 1'b1;
        end else begin
            rlevel        <= level_next;
            ralmost_empty <= (level_next <= PW'(AE_THRESH));
        end
    end
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb/tb_fifo_read_ctrl.sv - directed self-checking bench for fifo_read_ctrl (ASIZE=4, AE_THRESH=2)
module tb_fifo_read_ctrl;

    logic       rclk = 1'b0;
    logic       rrst = 1'b1;
    logic       rinc = 1'b0;
    logic [4:0] wptr_gray = 5'b00000;
    logic [4:0] rptr_gray;
    logic [3:0] raddr;
    logic       rempty;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    logic [4:0] rlevel;
    logic       ralmost_empty;
`endif

    int errors = 0;
    int checks = 0;

    always #5 rclk = ~rclk;

    fifo_read_ctrl #(.ASIZE(4), .AE_THRESH(2)) dut (
        .rclk          (rclk),
        .rrst          (rrst),
        .rinc          (rinc),
        .wptr_gray     (wptr_gray),
        .rptr_gray     (rptr_gray),
        .raddr         (raddr),
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        .rlevel        (rlevel),
        .ralmost_empty (ralmost_empty),
`endif
        .rempty        (rempty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge rclk);
            #1;
        end
    endtask

    function automatic logic [4:0] g(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    logic [4:0] prev_gray;

    initial begin
        // 1: reset, rinc held high has no effect
        rrst = 1'b1; rinc = 1'b1; wptr_gray = 5'b00000;
        tick(2);
        check("rst_rempty", 32'(rempty), 32'd1);
        check("rst_raddr", 32'(raddr), 32'd0);
        check("rst_rptr", 32'(rptr_gray), 32'd0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        check("rst_rlevel", 32'(rlevel), 32'd0);
        check("rst_ae", 32'(ralmost_empty), 32'd1);
`endif
        rrst = 1'b0;
        tick(3);
        check("idle_rempty", 32'(rempty), 32'd1);
        check("idle_rptr", 32'(rptr_gray), 32'd0);
        rinc = 1'b0;

        // 2: write-to-empty latency is three edges
        wptr_gray = g(1);
        tick(1);
        check("lat_e1", 32'(rempty), 32'd1);
        tick(1);
        check("lat_e2", 32'(rempty), 32'd1);
        tick(1);
        check("lat_e3", 32'(rempty), 32'd0);
        rinc = 1'b1;
        tick(1);
        check("pop1_raddr", 32'(raddr), 32'd1);
        check("pop1_rempty", 32'(rempty), 32'd1);
        check("pop1_rptr", 32'(rptr_gray), 32'(g(1)));
        tick(1);
        check("pop1_hold", 32'(rptr_gray), 32'(g(1)));
        rinc = 1'b0;

        // 3: drain a full FIFO
        rrst = 1'b1; wptr_gray = 5'b00000;
        tick(1);
        rrst = 1'b0;
        wptr_gray = g(16);
        tick(3);
        rinc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_raddr%0d", i), 32'(raddr), 32'(i));
            check($sformatf("drain_ne%0d", i), 32'(rempty), 32'd0);
            tick(1);
        end
        check("drain_rempty", 32'(rempty), 32'd1);
        check("drain_rptr", 32'(rptr_gray), 32'b11000);
        tick(1);
        check("drain_hold", 32'(rptr_gray), 32'b11000);
        rinc = 1'b0;

        // 4: 40 write/read pairs wrap the pointer through 31 -> 0
        for (int k = 0; k < 40; k++) begin
            prev_gray = rptr_gray;
            wptr_gray = g((17 + k) % 32);
            tick(3);
            check($sformatf("wrap_ne%0d", k), 32'(rempty), 32'd0);
            rinc = 1'b1;
            tick(1);
            rinc = 1'b0;
            check($sformatf("wrap_rptr%0d", k), 32'(rptr_gray), 32'(g((17 + k) % 32)));
            check($sformatf("wrap_1bit%0d", k), 32'($countones(rptr_gray ^ prev_gray)), 32'd1);
            check($sformatf("wrap_raddr%0d", k), 32'(raddr), 32'((17 + k) % 16));
            check($sformatf("wrap_empty%0d", k), 32'(rempty), 32'd1);
        end

        // 5: reset mid-operation with data present, then underflow attempts
        rrst = 1'b1;
        tick(1);
        rrst = 1'b0;
        wptr_gray = g(3);
        tick(3);
        rinc = 1'b1;
        tick(1);
        check("mid_raddr", 32'(raddr), 32'd1);
        check("mid_ne", 32'(rempty), 32'd0);
        rrst = 1'b1; wptr_gray = 5'b00000;
        tick(1);
        check("mid_rst_rempty", 32'(rempty), 32'd1);
        check("mid_rst_raddr", 32'(raddr), 32'd0);
        rrst = 1'b0;
        tick(3);
        check("under_rptr", 32'(rptr_gray), 32'd0);
        check("under_rempty", 32'(rempty), 32'd1);
        rinc = 1'b0;

`ifdef FIFO_RD_ALMOST_EMPTY_EN
        // 6: occupancy and almost-empty threshold
        wptr_gray = g(5);
        tick(3);
        check("ae_lvl5", 32'(rlevel), 32'd5);
        check("ae_flag5", 32'(ralmost_empty), 32'd0);
        rinc = 1'b1;
        tick(1);
        check("ae_lvl4", 32'(rlevel), 32'd4);
        tick(1);
        check("ae_lvl3", 32'(rlevel), 32'd3);
        check("ae_flag3", 32'(ralmost_empty), 32'd0);
        tick(1);
        rinc = 1'b0;
        check("ae_lvl2", 32'(rlevel), 32'd2);
        check("ae_flag2", 32'(ralmost_empty), 32'd1);
        check("ae_raddr", 32'(raddr), 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
